// File: rtl/zbus_pkg.sv
// zbus shared types: command decode, response bundle, pointer helper.
// Imported by the memory slave and its response FIFO.
package zbus_pkg;

  localparam int ZB_WA = 32;
  localparam int ZB_WD = 32;

  // Encoding is {aen, den}
  typedef enum logic [1:0] {
    CMD_RDB = 2'b00,
    CMD_WRB = 2'b01,
    CMD_RD  = 2'b10,
    CMD_WR  = 2'b11
  } cmd_t;

  typedef struct packed {
    logic [ZB_WA-1:0] adr;
    logic [ZB_WD-1:0] dat;
  } rsp_t;

  function automatic int unsigned next_ptr(
    input int unsigned p,
    input int unsigned depth
  );
    return (p + 1) % depth;
  endfunction

endpackage

// File: rtl/zbus_fifo.sv
// Small synchronous FIFO with registered storage and async reset.
// Output word is read straight from storage, so it holds until popped.
module zbus_fifo #(
  parameter int W  = 8,
  parameter int FD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (FD > 1) ? $clog2(FD) : 1;

  logic [W-1:0]  mem_q [FD];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FD; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din;
        wp_q        <= wp_q + 1'b1;
      end
      if (do_pop) begin
        rp_q <= rp_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign full  = (cnt_q == (PW+1)'(FD));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rp_q];

endmodule

// File: rtl/zbus_mem_slave.sv
// zbus memory slave: decodes w commands into a register-array memory
// with an auto-incrementing burst pointer; reads return via a FIFO.
module zbus_mem_slave
  import zbus_pkg::*;
#(
  parameter int WA    = ZB_WA,
  parameter int WD    = ZB_WD,
  parameter int DEPTH = 16,
  parameter int FD    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_vld,
  input  logic          w_aen,
  input  logic          w_den,
  input  logic [WA-1:0] w_adr,
  input  logic [WD-1:0] w_dat,
  output logic          w_rdy,
  output logic          r_vld,
  output logic          r_aen,
  output logic          r_den,
  output logic [WA-1:0] r_adr,
  output logic [WD-1:0] r_dat,
  input  logic          r_rdy
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          cmd;
  logic          xfer;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] idx;
  logic [AW-1:0] sel;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  logic [WD-1:0] mem_q [DEPTH];
  rsp_t          rsp_in;
  rsp_t          rsp_out;
  logic          full;
  logic          empty;
  logic          unused_adr;

  // Upper address bits are don't-care
  assign unused_adr = ^w_adr[WA-1:AW];

  assign w_rdy = ~rst & ~full;
  assign xfer  = w_vld & w_rdy;
  assign cmd   = cmd_t'({w_aen, w_den});
  assign idx   = w_adr[AW-1:0];
  assign wr_en = xfer & w_den;
  assign rd_en = xfer & ~w_den;

  always_comb begin
    sel = ptr_q;
    case (cmd)
      CMD_WR, CMD_RD:   sel = idx;
      CMD_WRB, CMD_RDB: sel = ptr_q;
      default:          sel = ptr_q;
    endcase
  end

  assign ptr_d = xfer ? AW'(next_ptr(32'(sel), DEPTH)) : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[sel] <= w_dat;
    end
  end

  assign rsp_in.adr = {{(WA-AW){1'b0}}, sel};
  assign rsp_in.dat = mem_q[sel];

  zbus_fifo #(
    .W  ($bits(rsp_t)),
    .FD (FD)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_en),
    .pop   (r_vld & r_rdy),
    .din   (rsp_in),
    .dout  (rsp_out),
    .full  (full),
    .empty (empty)
  );

  assign r_vld = ~empty;
  assign r_aen = r_vld;
  assign r_den = r_vld;
  assign r_adr = rsp_out.adr;
  assign r_dat = rsp_out.dat;

endmodule

// File: tb/tb_zbus_mem_slave.sv
// Bench for zbus_mem_slave: vector table, corner sequences and a
// randomised run, all checked through a response scoreboard.
module tb_zbus_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_vld, w_aen, w_den;
  logic [31:0] w_adr, w_dat;
  logic        w_rdy;
  logic        r_vld, r_aen, r_den;
  logic [31:0] r_adr, r_dat;
  logic        r_rdy;

  zbus_mem_slave dut (
    .clk   (clk),
    .rst   (rst),
    .w_vld (w_vld),
    .w_aen (w_aen),
    .w_den (w_den),
    .w_adr (w_adr),
    .w_dat (w_dat),
    .w_rdy (w_rdy),
    .r_vld (r_vld),
    .r_aen (r_aen),
    .r_den (r_den),
    .r_adr (r_adr),
    .r_dat (r_dat),
    .r_rdy (r_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    logic        aen;
    logic        den;
    logic [31:0] adr;
    logic [31:0] dat;
    bit          chk;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mmem [16];
  logic [3:0]  mptr;
  vec_t        vt [13];
  bit          rnd_done;
  bit          pv;
  logic [31:0] pa, pd;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  // Reference model, updated when a transfer is seen to happen
  task automatic model(input logic aen, input logic den,
                       input logic [31:0] adr, input logic [31:0] dat);
    logic [3:0] a;
    exp_t e;
    a = aen ? adr[3:0] : mptr;
    if (den) begin
      mmem[a] = dat;
    end else begin
      e.adr = {28'b0, a};
      e.dat = mmem[a];
      sbq.push_back(e);
    end
    mptr = a + 4'd1;
  endtask

  // Starts at posedge+1, returns at posedge+1 after the transfer
  task automatic send(input logic aen, input logic den,
                      input logic [31:0] adr, input logic [31:0] dat);
    bit done;
    done  = 0;
    w_vld = 1'b1;
    w_aen = aen;
    w_den = den;
    w_adr = adr;
    w_dat = dat;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (w_rdy) begin
        model(aen, den, adr, dat);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: actual w_rdy low, required accept");
    end
    w_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && r_vld && r_rdy) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_rsp: actual adr %h, required none", r_adr);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_adr", r_adr, mon_e.adr);
        check("rsp_dat", r_dat, mon_e.dat);
        check("rsp_flags", {30'b0, r_aen, r_den}, 32'h3);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pv = 0;
    end else begin
      if (pv) begin
        check("stable_vld", {31'b0, r_vld}, 32'h1);
        check("stable_adr", r_adr, pa);
        check("stable_dat", r_dat, pd);
      end
      pv = r_vld && !r_rdy;
      pa = r_adr;
      pd = r_dat;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 1'b1, 32'h3,        32'hA5A5_0001, 1'b0, 32'h0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 32'h3,        32'h0,         1'b1, 32'h3, 32'hA5A5_0001};
    vt[2]  = '{1'b1, 1'b1, 32'hE,        32'hE,         1'b0, 32'h0, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 32'h0,        32'h10,        1'b0, 32'h0, 32'h0};
    vt[4]  = '{1'b0, 1'b1, 32'h0,        32'h11,        1'b0, 32'h0, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 32'h0,        32'h12,        1'b0, 32'h0, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 32'hF,        32'h0,         1'b1, 32'hF, 32'h10};
    vt[7]  = '{1'b0, 1'b0, 32'h0,        32'h0,         1'b1, 32'h0, 32'h11};
    vt[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,         1'b1, 32'h1, 32'h12};
    vt[9]  = '{1'b1, 1'b1, 32'h5,        32'hBEEF_0005, 1'b0, 32'h0, 32'h0};
    vt[10] = '{1'b1, 1'b0, 32'h5,        32'h0,         1'b1, 32'h5, 32'hBEEF_0005};
    vt[11] = '{1'b1, 1'b1, 32'hFFFF_FF13, 32'h1357_2468, 1'b0, 32'h0, 32'h0};
    vt[12] = '{1'b1, 1'b0, 32'h0000_0023, 32'h0,         1'b1, 32'h3, 32'h1357_2468};

    rst   = 1'b1;
    r_rdy = 1'b1;
    w_vld = 1'b0;
    w_aen = 1'b0;
    w_den = 1'b0;
    w_adr = '0;
    w_dat = '0;
    mptr  = '0;
    #1;
    check("rst_r_vld", {31'b0, r_vld}, 32'h0);
    check("rst_w_rdy", {31'b0, w_rdy}, 32'h0);
    check("rst_flags", {30'b0, r_aen, r_den}, 32'h0);
    check("rst_r_adr", r_adr, 32'h0);
    check("rst_r_dat", r_dat, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_w_rdy", {31'b0, w_rdy}, 32'h1);

    for (int i = 0; i < 16; i++) begin
      send(1'b1, 1'b1, i, i * 32'h0101_0101);
    end

    // Table: single ops, wrap-around burst, write-then-read, upper bits
    for (int i = 0; i < 13; i++) begin
      send(vt[i].aen, vt[i].den, vt[i].adr, vt[i].dat);
      if (vt[i].chk) begin
        @(negedge clk);
        check($sformatf("vec%0d_vld", i), {31'b0, r_vld}, 32'h1);
        check($sformatf("vec%0d_adr", i), r_adr, vt[i].ea);
        check($sformatf("vec%0d_dat", i), r_dat, vt[i].ed);
        @(posedge clk);
        #1;
      end
    end

    // Backpressure: two reads fill the FIFO, third waits for a pop
    r_rdy = 1'b0;
    send(1'b1, 1'b0, 32'h7, 32'h0);
    send(1'b1, 1'b0, 32'h8, 32'h0);
    check("bp_w_rdy_low", {31'b0, w_rdy}, 32'h0);
    fork
      send(1'b1, 1'b0, 32'h9, 32'h0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_hold_rdy", {31'b0, w_rdy}, 32'h0);
          check("bp_hold_adr", r_adr, 32'h7);
          check("bp_hold_dat", r_dat, 32'h0707_0707);
        end
        @(posedge clk);
        #1;
        r_rdy = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_drained", sbq.size(), 32'h0);
    check("bp_w_rdy_back", {31'b0, w_rdy}, 32'h1);
    @(posedge clk);
    #1;

    // Reset with two responses queued
    r_rdy = 1'b0;
    send(1'b0, 1'b0, 32'h0, 32'h0);
    send(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("pre_rst_full", {31'b0, w_rdy}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_r_vld", {31'b0, r_vld}, 32'h0);
    check("mid_rst_w_rdy", {31'b0, w_rdy}, 32'h0);
    check("mid_rst_r_adr", r_adr, 32'h0);
    sbq.delete();
    mptr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    r_rdy = 1'b1;
    send(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_burst_vld", {31'b0, r_vld}, 32'h1);
    check("rst_burst_adr", r_adr, 32'h0);
    check("rst_burst_dat", r_dat, 32'h11);
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_stale", {31'b0, r_vld}, 32'h0);
    end
    @(posedge clk);
    #1;

    // Random traffic against the model
    rnd_done = 0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send($urandom_range(0, 1), $urandom_range(0, 1),
               $urandom, $urandom);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          r_rdy = $urandom_range(0, 1);
        end
      end
    join
    r_rdy = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rnd_drained", sbq.size(), 32'h0);
    check("rnd_idle_vld", {31'b0, r_vld}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/zbus_mem_slave.md
Name: zbus_mem_slave

Overview:
- Memory-mapped slave terminating a zbus: consumes the master's write channel (w) and returns read responses on the read channel (r).
- Sits directly downstream of a zbus master and is the endpoint for both p2p links. It holds a DEPTH-word register-array memory with an auto-incrementing burst pointer.
- A small response FIFO decouples read responses from read-channel backpressure.

Parameters:
- WA, 32, address width of both channels
- WD, 32, data width of both channels
- DEPTH, 16, memory words (power of 2); index AW = $clog2(DEPTH) LSBs of address
- FD, 2, response FIFO depth (power of 2, >= 2)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- w_vld  input  1  command valid
- w_aen  input  1  command carries an address
- w_den  input  1  command carries write data
- w_adr  input  WA  command address
- w_dat  input  WD  write data
- w_rdy  output  1  command accepted when w_vld & w_rdy
- r_vld  output  1  response valid
- r_aen  output  1  response address-valid flag, always 1 when r_vld
- r_den  output  1  response data-valid flag, always 1 when r_vld
- r_adr  output  WA  read address, index zero-extended
- r_dat  output  WD  read data
- r_rdy  input  1  response accepted when r_vld & r_rdy

Behaviour:
- Reset is asynchronous, active-high, with clock clk. While reset is asserted:
  - r_vld = 0, FIFO empty, pointer ptr = 0, w_rdy = 0.
  - r_aen, r_den, r_adr and r_dat are 0.
  - Memory contents are not reset.
- w_rdy = !rst & (fifo_count != FD). It is registered-free and comes only from FIFO state; it does not depend on w_vld or w_* decode. There is no pass-through when the FIFO is full, even if r_rdy pops in the same cycle.
- Command decode applies on a w transfer, i.e. when w_vld & w_rdy:
  - aen=1, den=1: write mem[w_adr[AW-1:0]] <= w_dat; ptr <= idx+1.
  - aen=0, den=1: burst write mem[ptr] <= w_dat; ptr <= ptr+1.
  - aen=1, den=0: read request at idx; push {idx, mem[idx]} to FIFO; ptr <= idx+1.
  - aen=0, den=0: burst read at ptr; push {ptr, mem[ptr]}; ptr <= ptr+1.
- ptr arithmetic is modulo DEPTH, so it wraps from DEPTH-1 to 0. Upper address bits are ignored.
- Commands execute in order. A read transfer returns memory contents as of that cycle, i.e. it sees every write accepted in earlier cycles.
- Read latency: a read transfer in cycle N gives r_vld = 1 in cycle N+1, provided the FIFO was empty. The FIFO output is registered.
- Response stability: while r_vld & !r_rdy, r_adr and r_dat must not change.
- FIFO handling:
  - Push and pop in the same cycle leave count unchanged.
  - Pop when empty is impossible, because r_vld = count != 0.
- Reset asserted mid-burst: ptr and FIFO clear immediately, and pending responses are discarded.

Decomposition:
- Package zbus_pkg:
  - enum cmd_t {CMD_WR, CMD_WRB, CMD_RD, CMD_RDB}, decoded from {aen, den}
  - struct rsp_t {adr, dat}
  - function next_ptr(), doing the modulo-DEPTH increment
- Sub-module zbus_fifo:
  - generic synchronous FIFO (parameters W, FD)
  - ports push/pop/din/dout/full/empty, async reset
  - instantiated once for rsp_t
- Top-level zbus_mem_slave holds the decoder, ptr register and memory array.

Test Plan:
1. Write 0xA5A5_0001 at adr 3 (aen=1, den=1), then read adr 3 (aen=1, den=0) with r_rdy=1 -> one cycle after the read transfer: r_vld=1, r_adr=3, r_dat=0xA5A5_0001.
2. Write adr 14, then 3 burst writes (aen=0, den=1) of 0x10, 0x11, 0x12 -> the burst writes land at 15, 0 and 1 (wrap). A burst read starting at adr 15 then returns (15, 0x10), (0, 0x11), (1, 0x12).
3. Hold r_rdy=0 and issue 3 reads with FD=2 -> w_rdy drops after the 2nd read transfer. r_adr and r_dat stay stable. Raising r_rdy drains in order and w_rdy reasserts.
4. A write to adr 5 immediately followed by a read of adr 5 in the next cycle -> r_dat equals the new data (no stale read).
5. Assert rst mid-burst with 2 responses queued -> r_vld=0 and w_rdy=0 during reset. After reset, a burst read starts at ptr=0 and no old responses appear.
6. Random vld/r_rdy toggling over 1000 commands against a reference model -> every response matches the model, in order, and there are no stability violations.
